// File: rtl/muldiv_arbiter.sv
// rtl/muldiv_arbiter.sv - two-port arbiter in front of a shared MUL/DIV unit, one operation in flight
// Optional round-robin tie-break: define MULDIV_ARB_RR_EN; otherwise port 0 has fixed priority.
module muldiv_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             p0_req_i,
    input  logic [31:0]      p0_instr_bi,
    input  logic [31:0]      p0_src0_bi,
    input  logic [31:0]      p0_src1_bi,
    output logic             p0_ack_o,
    output logic             p0_resp_req_o,
    output logic [31:0]      p0_resp_wdata_bo,
    input  logic             p0_resp_ack_i,
    output logic [CNT_W-1:0] p0_ops_bo,

    input  logic             p1_req_i,
    input  logic [31:0]      p1_instr_bi,
    input  logic [31:0]      p1_src0_bi,
    input  logic [31:0]      p1_src1_bi,
    output logic             p1_ack_o,
    output logic             p1_resp_req_o,
    output logic [31:0]      p1_resp_wdata_bo,
    input  logic             p1_resp_ack_i,
    output logic [CNT_W-1:0] p1_ops_bo,

    output logic             exu_req_o,
    output logic [31:0]      exu_instr_bo,
    output logic [31:0]      exu_src0_bo,
    output logic [31:0]      exu_src1_bo,
    input  logic             exu_ack_i,
    input  logic             exu_resp_req_i,
    input  logic [31:0]      exu_resp_wdata_bi,
    output logic             exu_resp_ack_o,

    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic [31:0]       instr_q;
    logic [31:0]       src0_q;
    logic [31:0]       src1_q;
    logic [31:0]       result_q;
    logic              gnt_q;
    logic [CNT_W-1:0]  ops0_q;
    logic [CNT_W-1:0]  ops1_q;
    logic              grant_p0;
    logic              grant_any;
    logic              resp_done;

`ifdef MULDIV_ARB_RR_EN
    // last_q holds the index of the previous winner; a tie goes to the other port
    logic              last_q;
    assign grant_p0 = p0_req_i & (~p1_req_i | last_q);
`else
    assign grant_p0 = p0_req_i;
`endif

    assign grant_any = p0_req_i | p1_req_i;
    assign resp_done = gnt_q ? p1_resp_ack_i : p0_resp_ack_i;

    assign p0_ack_o = (state == IDLE) & grant_p0;
    assign p1_ack_o = (state == IDLE) & p1_req_i & ~grant_p0;

    assign exu_req_o      = (state == ISSUE);
    assign exu_instr_bo   = instr_q;
    assign exu_src0_bo    = src0_q;
    assign exu_src1_bo    = src1_q;
    assign exu_resp_ack_o = 1'b1;

    assign p0_resp_req_o    = (state == RESP) & ~gnt_q;
    assign p1_resp_req_o    = (state == RESP) & gnt_q;
    assign p0_resp_wdata_bo = p0_resp_req_o ? result_q : 32'd0;
    assign p1_resp_wdata_bo = p1_resp_req_o ? result_q : 32'd0;

    assign p0_ops_bo = ops0_q;
    assign p1_ops_bo = ops1_q;
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            instr_q  <= 32'd0;
            src0_q   <= 32'd0;
            src1_q   <= 32'd0;
            result_q <= 32'd0;
            gnt_q    <= 1'b0;
            ops0_q   <= '0;
            ops1_q   <= '0;
`ifdef MULDIV_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        instr_q <= grant_p0 ? p0_instr_bi : p1_instr_bi;
                        src0_q  <= grant_p0 ? p0_src0_bi  : p1_src0_bi;
                        src1_q  <= grant_p0 ? p0_src1_bi  : p1_src1_bi;
                        gnt_q   <= ~grant_p0;
`ifdef MULDIV_ARB_RR_EN
                        last_q  <= ~grant_p0;
`endif
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (exu_ack_i) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (exu_resp_req_i) begin
                        result_q <= exu_resp_wdata_bi;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (resp_done) begin
                        // counters saturate at all-ones rather than wrapping
                        if (!gnt_q && ops0_q != '1) begin
                            ops0_q <= ops0_q + 1'b1;
                        end
                        if (gnt_q && ops1_q != '1) begin
                            ops1_q <= ops1_q + 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// tb/tb_muldiv_arbiter.sv - directed self-checking bench for muldiv_arbiter
module tb_muldiv_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        p0_req, p1_req, p0_ack, p1_ack;
    logic [31:0] p0_instr, p0_src0, p0_src1, p1_instr, p1_src0, p1_src1;
    logic        p0_resp_req, p1_resp_req, p0_resp_ack, p1_resp_ack;
    logic [31:0] p0_wdata, p1_wdata;
    logic [3:0]  p0_ops, p1_ops;
    logic        exu_req, exu_ack, exu_resp_req, exu_resp_ack, busy;
    logic [31:0] exu_instr, exu_src0, exu_src1, exu_resp_wdata;

    muldiv_arbiter #(.CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .p0_req_i(p0_req), .p0_instr_bi(p0_instr), .p0_src0_bi(p0_src0), .p0_src1_bi(p0_src1),
        .p0_ack_o(p0_ack), .p0_resp_req_o(p0_resp_req), .p0_resp_wdata_bo(p0_wdata),
        .p0_resp_ack_i(p0_resp_ack), .p0_ops_bo(p0_ops),
        .p1_req_i(p1_req), .p1_instr_bi(p1_instr), .p1_src0_bi(p1_src0), .p1_src1_bi(p1_src1),
        .p1_ack_o(p1_ack), .p1_resp_req_o(p1_resp_req), .p1_resp_wdata_bo(p1_wdata),
        .p1_resp_ack_i(p1_resp_ack), .p1_ops_bo(p1_ops),
        .exu_req_o(exu_req), .exu_instr_bo(exu_instr), .exu_src0_bo(exu_src0), .exu_src1_bo(exu_src1),
        .exu_ack_i(exu_ack), .exu_resp_req_i(exu_resp_req), .exu_resp_wdata_bi(exu_resp_wdata),
        .exu_resp_ack_o(exu_resp_ack), .busy_o(busy)
    );

    // MUL/DIV unit model: accepts immediately, result pulse two cycles after accept
    logic        m_v1, m_pulse, stray;
    logic [31:0] m_r1, m_data, stray_data;

    function automatic logic [31:0] calc(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        case (ins[14:12])
            3'd0:    calc = a * b;
            3'd4:    calc = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: calc = a + b;
        endcase
    endfunction

    assign exu_ack        = exu_req;
    assign exu_resp_req   = m_pulse | stray;
    assign exu_resp_wdata = stray ? stray_data : m_data;

    always @(posedge clk) begin
        if (rst) begin
            m_v1 <= 1'b0; m_pulse <= 1'b0; m_r1 <= 32'd0; m_data <= 32'd0;
        end else begin
            m_v1    <= exu_req & exu_ack;
            m_r1    <= calc(exu_instr, exu_src0, exu_src1);
            m_pulse <= m_v1;
            m_data  <= m_r1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Starts just after a rising edge; returns just after the edge that completes the response handshake.
    task automatic run_op(input logic r0, input logic r1, input logic [31:0] ins,
                          input logic [31:0] a, input logic [31:0] b,
                          output int gnt, output logic [31:0] data);
        int k;
        p0_req = r0; p1_req = r1;
        p0_instr = ins; p0_src0 = a; p0_src1 = b;
        p1_instr = ins; p1_src0 = a; p1_src1 = b;
        @(negedge clk);
        gnt = p1_ack ? 1 : (p0_ack ? 0 : -1);
        @(posedge clk); #1;
        p0_req = 1'b0; p1_req = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (p0_resp_req || p1_resp_req) break;
        end
        chk("op_completes", {31'd0, k < 20}, 32'd1);
        data = p1_resp_req ? p1_wdata : p0_wdata;
        if (p1_resp_req) p1_resp_ack = 1'b1;
        else             p0_resp_ack = 1'b1;
        @(posedge clk); #1;
        p0_resp_ack = 1'b0; p1_resp_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g;
        logic [31:0] d;
        logic        seen;
        int          exp_g [3];

        p0_req = 0; p1_req = 0; p0_resp_ack = 0; p1_resp_ack = 0;
        p0_instr = 0; p0_src0 = 0; p0_src1 = 0; p1_instr = 0; p1_src0 = 0; p1_src1 = 0;
        stray = 0; stray_data = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_exu_req", {31'd0, exu_req}, 32'd0);
        chk("rst_exu_instr", exu_instr, 32'd0);
        chk("rst_exu_src0", exu_src0, 32'd0);
        chk("rst_p0_ops", {28'd0, p0_ops}, 32'd0);
        chk("rst_p1_ops", {28'd0, p1_ops}, 32'd0);
        chk("rst_resp_req", {30'd0, p0_resp_req, p1_resp_req}, 32'd0);
        chk("rst_exu_resp_ack", {31'd0, exu_resp_ack}, 32'd1);

        // MUL 7*6 on port 0, cycle-accurate latency
        @(posedge clk); #1;
        p0_req = 1; p0_instr = 32'd0; p0_src0 = 32'd7; p0_src1 = 32'd6;
        @(negedge clk);
        chk("c0_acks", {30'd0, p1_ack, p0_ack}, 32'd1);
        @(posedge clk); #1 p0_req = 0;
        @(negedge clk);
        chk("c1_exu_req", {31'd0, exu_req}, 32'd1);
        chk("c1_exu_src0", exu_src0, 32'd7);
        chk("c1_exu_src1", exu_src1, 32'd6);
        chk("c1_busy", {31'd0, busy}, 32'd1);
        chk("c1_p0_ack", {31'd0, p0_ack}, 32'd0);
        @(negedge clk);
        chk("c2_exu_req", {31'd0, exu_req}, 32'd0);
        @(negedge clk);
        chk("c3_resp_req", {31'd0, p0_resp_req}, 32'd0);
        @(negedge clk);
        chk("c4_resp_req", {31'd0, p0_resp_req}, 32'd1);
        chk("c4_wdata", p0_wdata, 32'd42);
        chk("c4_p1_resp_req", {31'd0, p1_resp_req}, 32'd0);
        chk("c4_p1_wdata", p1_wdata, 32'd0);
        p0_resp_ack = 1;
        @(posedge clk); #1 p0_resp_ack = 0;
        @(negedge clk);
        chk("mul_p0_ops", {28'd0, p0_ops}, 32'd1);
        chk("mul_idle", {31'd0, busy}, 32'd0);
        chk("mul_resp_drop", {31'd0, p0_resp_req}, 32'd0);

        // request withdrawn before any edge samples it
        @(posedge clk); #1 p0_req = 1;
        #3 p0_req = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("withdraw_busy", {31'd0, busy}, 32'd0);

        // long RESP hold with a stray result pulse and a competing request
        @(posedge clk); #1;
        p1_req = 1; p1_instr = 32'd0; p1_src0 = 32'd3; p1_src1 = 32'd5;
        @(posedge clk); #1 p1_req = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (p1_resp_req) break;
        end
        chk("hold_enter", {31'd0, p1_resp_req}, 32'd1);
        p0_req = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 stray = (i == 3);
            @(negedge clk);
            chk("hold_resp_req", {31'd0, p1_resp_req}, 32'd1);
            chk("hold_wdata", p1_wdata, 32'd15);
            chk("hold_no_accept", {30'd0, p1_ack, p0_ack}, 32'd0);
        end
        stray = 0; p0_req = 0; p1_resp_ack = 1;
        @(posedge clk); #1 p1_resp_ack = 0;
        @(negedge clk);
        chk("hold_done_busy", {31'd0, busy}, 32'd0);
        chk("hold_done_wdata", p1_wdata, 32'd0);
        chk("hold_p1_ops", {28'd0, p1_ops}, 32'd1);

        // reset while waiting for the unit
        @(posedge clk); #1;
        p0_req = 1; p0_instr = 32'd0; p0_src0 = 32'd2; p0_src1 = 32'd2;
        @(posedge clk); #1 p0_req = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wait_state_busy", {31'd0, busy}, 32'd1);
        chk("wait_state_exu_req", {31'd0, exu_req}, 32'd0);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_p0_ops", {28'd0, p0_ops}, 32'd0);
        chk("mid_rst_p1_ops", {28'd0, p1_ops}, 32'd0);
        chk("mid_rst_src0", exu_src0, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | p0_resp_req | p1_resp_req;
        end
        chk("mid_rst_no_resp", {31'd0, seen}, 32'd0);

        // three rounds of simultaneous requests
`ifdef MULDIV_ARB_RR_EN
        exp_g = '{0, 1, 0};
`else
        exp_g = '{0, 0, 0};
`endif
        @(posedge clk); #1;
        for (int r = 0; r < 3; r++) begin
            run_op(1'b1, 1'b1, 32'd0, r + 1, 32'd10, g, d);
            chk($sformatf("tie_grant_%0d", r), g, exp_g[r]);
            chk($sformatf("tie_data_%0d", r), d, (r + 1) * 10);
        end

        // counter saturation with CNT_W=4, DIV operations on port 1
        rst = 1;
        @(posedge clk); #1 rst = 0;
        for (int i = 1; i <= 16; i++) begin
            run_op(1'b0, 1'b1, 32'h0000_4000, i * 6, 32'd3, g, d);
            if (i == 1 || i == 16) chk($sformatf("div_data_%0d", i), d, i * 2);
            if (i == 15) chk("sat_p1_ops_15", {28'd0, p1_ops}, 32'd15);
        end
        chk("sat_p1_ops_16", {28'd0, p1_ops}, 32'd15);
        chk("sat_p0_ops", {28'd0, p0_ops}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_arbiter.md
MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 Parameter CNT_W, default 16, width of per-port completed-operation counters; legal range 4..32.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset: clk_i and rst_i.
REQ-003 clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 pN_req_i (N=0,1)  input  1  request valid from requester N.
REQ-006 pN_instr_bi  input  32  instruction word; bits [14:12] select the operation.
REQ-007 pN_src0_bi / pN_src1_bi  input  32 each  operands.
REQ-008 pN_ack_o  output  1  request accepted this cycle.
REQ-009 pN_resp_req_o  output  1  result valid to requester N.
REQ-010 pN_resp_wdata_bo  output  32  result data.
REQ-011 pN_resp_ack_i  input  1  requester N consumes the result.
REQ-012 pN_ops_bo  output  CNT_W  completed-operation count for port N.
REQ-013 exu_req_o / exu_instr_bo / exu_src0_bo / exu_src1_bo  output  1/32/32/32  request to the shared MUL/DIV unit.
REQ-014 exu_ack_i  input  1  MUL/DIV unit accepts the request.
REQ-015 exu_resp_req_i / exu_resp_wdata_bi  input  1/32  one-cycle result pulse and data from the MUL/DIV unit.
REQ-016 exu_resp_ack_o  output  1  tied to 1.
REQ-017 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP; it allows one operation in flight.
REQ-019 IDLE: if any pN_req_i is high, assert pN_ack_o combinationally for the granted port only, latch its instr/src0/src1 into operand registers, record the grant index, and go to ISSUE.
REQ-020 pN_ack_o SHALL be 0 in every state other than IDLE.
REQ-021 ISSUE: exu_req_o=1 with the latched operands; on exu_ack_i go to WAIT.
REQ-022 In every state other than ISSUE, exu_req_o=0; exu_*_bo SHALL always show the latched operands.
REQ-023 WAIT: on exu_resp_req_i, capture exu_resp_wdata_bi into the result register and go to RESP; there is no timeout.
REQ-024 exu_resp_req_i outside WAIT SHALL be ignored.
REQ-025 RESP: assert resp_req_o for the granted port only, with wdata taken from the result register; hold until that port's resp_ack_i, then go to IDLE.
REQ-026 A new accept SHALL be possible at the earliest in the cycle after leaving RESP.
REQ-027 Each non-granted port's resp_req_o=0 and resp_wdata_bo=0; its resp_ack_i SHALL be ignored.
REQ-028 pN_ops_bo SHALL increment by 1 on each completed RESP handshake for port N, saturating at all-ones with no wrap.
REQ-029 Latency for MUL (the unit's result arrives 2 cycles after exu accept): accept in cycle 0, exu_req_o in cycle 1, pN_resp_req_o first high in cycle 4.
REQ-030 A requester that drops req_i before it is acked SHALL NOT be served; no state changes.

Reset
REQ-031 rst_i SHALL force, on the next edge: FSM to IDLE; all ack/req outputs 0; result, operand and grant registers 0; pN_ops_bo 0; round-robin pointer to 1 (port 0 wins the first tie).
REQ-032 Reset in the middle of an operation SHALL discard it with no response issued; the MUL/DIV unit shares rst_i.

Configuration
REQ-033 Macro MULDIV_ARB_RR_EN: when defined, simultaneous requests SHALL be granted to the port that did not win the last grant; the pointer updates only on accept.
REQ-034 When MULDIV_ARB_RR_EN is undefined, port 0 SHALL always win a tie (fixed priority); the pointer logic is absent.

Verification
REQ-035 p0 only, MUL instr[14:12]=0, src0=7, src1=6; exu model returns 42 two cycles after accept -> p0_ack_o in cycle 0, p0_resp_req_o in cycle 4 with wdata 42, p0_ops_bo=1.
REQ-036 p0 and p1 request together in three consecutive rounds, with MULDIV_ARB_RR_EN defined -> grants p0, p1, p0; with it undefined -> p0, p0, p0 while p1 starves.
REQ-037 Hold pN_resp_ack_i low 10 cycles in RESP, and pulse exu_resp_req_i with 0xDEADBEEF during RESP -> resp_req_o and wdata stay stable, the stray pulse is ignored, no new accept occurs.
REQ-038 Assert rst_i during WAIT -> next cycle IDLE, busy_o=0, counters 0, no resp_req_o ever issued for the dropped operation.
REQ-039 CNT_W=4, sixteen p1 operations -> p1_ops_bo=15 after the 15th and stays 15 after the 16th; p0_ops_bo remains 0.
